iterative_alu: RTL and testbench

//   Execute-stage ALU fed by the ALU_sel output of the ALU control unit. Operands and the

---
 rtl/iterative_alu.sv | 156 +++++++++++++++
 tb/tb_iterative_alu.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops, iterative shifts at SHIFT_STEP bits per cycle.
// Latency: 1 cycle for non-shift ops and zero shifts; 1 + ceil(shamt/SHIFT_STEP) cycles for shifts.
// Backpressure: start is accepted only while busy is low; a start seen while busy is dropped.
module iterative_alu #(
    parameter int WIDTH      = 32,
    parameter int SHAMT_W    = 5,
    parameter int SHIFT_STEP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         alu_sel,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   result,
    output logic               zf,
    output logic               cf,
    output logic               vf,
    output logic               sf,
    output logic               busy,
    output logic               done
);

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLT  = 4'h5;
    localparam logic [3:0] ALU_SLTU = 4'h6;
    localparam logic [3:0] ALU_SLL  = 4'h7;
    localparam logic [3:0] ALU_SRL  = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'h9;
    localparam logic [3:0] ALU_PASS = 4'hA;

    localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t               state;
    logic [3:0]           sel_q;
    logic [WIDTH-1:0]     work;
    logic [SHAMT_W-1:0]   count;

    logic [WIDTH-1:0]     bx;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     comb_res;
    logic                 comb_cf;
    logic                 comb_vf;
    logic                 is_shift;
    logic [SHAMT_W-1:0]   shamt;
    logic [SHAMT_W-1:0]   step;
    logic [WIDTH-1:0]     work_nxt;
    logic [SHAMT_W-1:0]   count_nxt;

    // Single-cycle datapath, evaluated on the live inputs at the accepting edge.
    always_comb begin
        bx       = (alu_sel == ALU_SUB) ? ~b : b;
        sum      = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, (alu_sel == ALU_SUB)};
        comb_res = b;
        comb_cf  = 1'b0;
        comb_vf  = 1'b0;
        shamt    = b[SHAMT_W-1:0];
        is_shift = (alu_sel == ALU_SLL) || (alu_sel == ALU_SRL) || (alu_sel == ALU_SRA);
        case (alu_sel)
            ALU_ADD, ALU_SUB: begin
                comb_res = sum[WIDTH-1:0];
                comb_cf  = sum[WIDTH];
                comb_vf  = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:  comb_res = a & b;
            ALU_OR:   comb_res = a | b;
            ALU_XOR:  comb_res = a ^ b;
            ALU_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: comb_res = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL, ALU_SRL, ALU_SRA: comb_res = a;   // only reached with shamt == 0
            ALU_PASS: comb_res = b;
            default:  comb_res = b;
        endcase
    end

    // One shift step; SRA keeps the MSB, which is the latched sign of a.
    always_comb begin
        step      = (count < STEP) ? count : STEP;
        count_nxt = count - step;
        case (sel_q)
            ALU_SLL: work_nxt = work << step;
            ALU_SRA: work_nxt = $signed(work) >>> step;
            default: work_nxt = work >> step;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sel_q  <= 4'h0;
            work   <= '0;
            count  <= '0;
            result <= '0;
            zf     <= 1'b0;
            cf     <= 1'b0;
            vf     <= 1'b0;
            sf     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        sel_q <= alu_sel;
                        work  <= a;
                        count <= shamt;
                        if (is_shift && (shamt != '0)) begin
                            state <= SHIFT;
                        end else begin
                            state  <= FINISH;
                            done   <= 1'b1;
                            result <= comb_res;
                            zf     <= (comb_res == '0);
                            cf     <= comb_cf;
                            vf     <= comb_vf;
                            sf     <= comb_res[WIDTH-1];
                        end
                    end
                end
                SHIFT: begin
                    work  <= work_nxt;
                    count <= count_nxt;
                    if (count_nxt == '0) begin
                        state  <= FINISH;
                        done   <= 1'b1;
                        result <= work_nxt;
                        zf     <= (work_nxt == '0);
                        cf     <= 1'b0;
                        vf     <= 1'b0;
                        sf     <= work_nxt[WIDTH-1];
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu: directed ops push expectations, a monitor checks each done.
module tb_iterative_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  alu_sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zf, cf, vf, sf, busy, done;

    iterative_alu #(.WIDTH(32), .SHAMT_W(5), .SHIFT_STEP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_sel(alu_sel), .a(a), .b(b),
        .result(result), .zf(zf), .cf(cf), .vf(vf), .sf(sf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;   // {zf, cf, vf, sf}
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_flags"}, {28'h0, zf, cf, vf, sf}, {28'h0, e.flags});
                check({e.name, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
                check({e.name, "_busy"}, {31'h0, busy}, 32'h1);
            end
        end
    end

    // Called at a rising edge: drives start for one cycle and records the expectation.
    task automatic issue(input string name, input logic [3:0] sel, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] res, input logic [3:0] flg,
                         input int lat);
        exp_t e;
        #1;
        alu_sel = sel; a = av; b = bv; start = 1'b1;
        e.res = res; e.flags = flg; e.lat = lat; e.t0 = cyc; e.name = name;
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 32'h5A5A_5A5A; b = 32'hA5A5_A5A5; alu_sel = 4'h0;
    endtask

    // Returns at a rising edge once every expectation has been consumed.
    task automatic wait_idle(input string name);
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic run(input string name, input logic [3:0] sel, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] res, input logic [3:0] flg,
                       input int lat);
        issue(name, sel, av, bv, res, flg, lat);
        wait_idle(name);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_result"}, result, 32'h0);
        check({name, "_ctl"}, {26'h0, zf, cf, vf, sf, busy, done}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; alu_sel = 4'h0; a = '0; b = '0;
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);

        //    name         sel    a              b              result         {z,c,v,s} lat
        run("add_ovf",   4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011, 1);
        run("sub_eq",    4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1100, 1);
        run("sub_neg",   4'h1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0001, 1);
        run("add_wrap",  4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100, 1);
        run("sra31",     4'h9, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 4'b0001, 32);
        run("srl31",     4'h8, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000, 32);
        run("sll0",      4'h7, 32'h00000001, 32'h00000000, 32'h00000001, 4'b0000, 1);
        run("sll3",      4'h7, 32'h00000001, 32'hFFFFFFE3, 32'h00000008, 4'b0000, 4);
        run("slt",       4'h5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1);
        run("sltu",      4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000, 1);
        run("undef",     4'hE, 32'h12345678, 32'h0000DEAD, 32'h0000DEAD, 4'b0000, 1);
        run("and",       4'h2, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 4'b0000, 1);
        run("or",        4'h3, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 4'b0000, 1);
        run("xor",       4'h4, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 4'b0000, 1);
        run("pass",      4'hA, 32'h00000000, 32'h87654321, 32'h87654321, 4'b0001, 1);
        run("sra4_pos",  4'h9, 32'h40000000, 32'h00000004, 32'h04000000, 4'b0000, 5);

        // Start pulses while busy must be dropped with no extra result.
        issue("sll20", 4'h7, 32'h00000001, 32'h00000014, 32'h00100000, 4'b0000, 21);
        repeat (3) @(posedge clk);
        #1;
        check("busy_mid_shift", {31'h0, busy}, 32'h1);
        alu_sel = 4'h0; a = 32'h2; b = 32'h3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle("sll20");
        repeat (3) @(posedge clk);

        // Reset mid-shift discards the operation.
        issue("sll20_rst", 4'h7, 32'h00000001, 32'h00000014, 32'h00100000, 4'b0000, 21);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        #3;
        check_zero_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check_zero_outputs("post_reset");
        @(posedge clk);
        run("add_after_rst", 4'h0, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000, 1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
